mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer that shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and its memory-access (MA) load/store requester. Each cycle it decides which requester owns the memory port and drives a req/ack transaction to the memory. It aligns store data and byte enables, and returns per-requester done pulses and stall signals to the hazard unit. It sits between the CPU's `pc_out`/`instr_if` and `alu_result_ma`/`mem_*_ma` signals and the memory model.

## Interface
- `TIMEOUT`, default 255: cycles a transaction may wait for `mem_ack` before it is aborted.
- `IF_STARVE`, default 4: number of consecutive IF losses after which IF wins the next arbitration.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_done`.
- `if_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `if_rdata` out 32: fetched word; valid only while `if_done` is high.
- `if_done` out 1: one-cycle completion pulse for the fetch.
- `if_stall` out 1: equals `if_req & ~if_done`.
- `mem_read_ma` in 2: load width: 00 none, 01 byte, 10 half, 11 word.
- `mem_write_ma` in 2: store width, same encoding; it is illegal for both `mem_read_ma` and `mem_write_ma` to be nonzero.
- `ma_addr` in 32: load/store byte address.
- `ma_wdata` in 32: store data, right-justified.
- `ma_rdata` out 32: raw memory word, not sign-extended; valid while `ma_done` is high.
- `ma_done` out 1: one-cycle completion pulse for the load/store.
- `ma_stall` out 1: equals `ma_req & ~ma_done`, where `ma_req = |mem_read_ma | |mem_write_ma`.
- `mem_req` out 1: request to memory; held until ack or abort.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word-aligned address, with bits [1:0] forced to 00.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-aligned store data.
- `mem_ack` in 1: one-cycle acknowledge; read data is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `err` out 1: one-cycle pulse when a transaction times out.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MA, RECOVER.
- IDLE, when at least one request is pending:
  - Arbitration is priority MA > IF. The exception is `starve_cnt == IF_STARVE`, in which case IF wins.
  - The winner's request is latched into the `mem_*` registers and the FSM moves to BUSY_IF or BUSY_MA.
- `starve_cnt` (width = clog2(IF_STARVE+1)):
  - Increments when MA wins while `if_req` is high.
  - Clears when IF wins.
  - Saturates at `IF_STARVE`.
- BUSY_x behaviour:
  - `mem_req` is held high and the latched `mem_addr`/`mem_be`/`mem_wdata`/`mem_we` are held stable.
  - On `mem_ack`: pulse `x_done` in the same cycle, pass `mem_rdata` through to `x_rdata`, drop `mem_req` at the next edge, and go to RECOVER.
- Timeout:
  - A timer counts cycles spent in BUSY_x.
  - When the timer reaches `TIMEOUT` without an ack: pulse `x_done` and `err`, force `x_rdata` to 0, drop `mem_req`, and go to RECOVER.
- RECOVER lasts one cycle with no grant (the requester deasserts or changes its request), then the FSM returns to IDLE.
- Store alignment, with `off = ma_addr[1:0]`:
  - Byte store: `mem_be = 0001 << off`; `mem_wdata` = the byte replicated into all 4 lanes.
  - Half store: `mem_be = 0011 << off[1]*2`; `mem_wdata` = the halfword replicated into both halves.
  - Word store: `mem_be = 1111`.
  - Misaligned halfword/word accesses are not checked; `off` is truncated.
- Loads:
  - `mem_be` is 1111 for every load width.
  - `mem_we` is 0.
- A fetch always uses `mem_be = 1111` and `mem_we = 0`.
- Requests arriving in BUSY or RECOVER wait in the requester; the arbiter has no queue.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `if_done`, `ma_done`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - `starve_cnt` and the timer = 0.
  - State = IDLE.
- `if_stall`/`ma_stall` are combinational and follow their inputs during reset.
- Latency:
  - Request seen in IDLE at cycle N → `mem_req` high at N+1.
  - With a zero-wait memory (ack in N+1), `done` is at N+1, RECOVER at N+2, and the next grant is possible at N+3.
  - Peak throughput is one transaction per 3 cycles.
- Simultaneous `mem_ack` and timeout expiry in the same cycle: the ack wins and `err` is not pulsed.
- Simultaneous IF and MA requests in IDLE: resolved per the starve rule; the loser's stall stays high.
- Reset asserted mid-transaction: `mem_req` drops at that edge, no `done` is issued, and the FSM goes to IDLE. A `mem_ack` arriving afterwards is ignored.
- A `mem_ack` while not in BUSY is ignored.

## Structure
- Package `mem_arb_pkg`:
  - Width encoding constants `MW_NONE`, `MW_BYTE`, `MW_HALF`, `MW_WORD`.
  - FSM state enum.
  - `TIMEOUT` default.
- Sub-module `store_lane_align`: combinational; inputs width, `off`, `ma_wdata`; outputs `be` and `wdata`. It is unit-testable on its own.
- Top-level `mem_port_arbiter` contains the FSM, starve counter, timeout timer and output registers.

## Test plan
- IF-only: `if_addr=0x10` with a zero-wait memory → `mem_req` at N+1 with `mem_addr=0x10`, `mem_be=1111`; `if_done` at N+1 with `if_rdata` equal to `mem_rdata`.
- Contention: `if_req` and an MA word load to `0x08` raised at the same time → the MA load is granted first; the IF fetch is granted 2 cycles after `ma_done`; `if_stall` stays high throughout.
- Starvation: MA requests back-to-back while `if_req` stays high → IF wins the 5th arbitration (after 4 MA wins); `starve_cnt` then clears.
- Store lanes:
  - SB of `0xAB` to address `0x13` → `mem_be=1000`, `mem_wdata=0xABABABAB`.
  - SH of `0x1234` to address `0x12` → `mem_be=1100`, `mem_wdata=0x12341234`.
- Timeout: a memory that never acks, with `TIMEOUT=8` → `err` and `ma_done` pulse 8 cycles after `mem_req` rises; `ma_rdata=0`; the arbiter returns to IDLE.
- Reset mid-operation: `reset` asserted 2 cycles into BUSY_MA → `mem_req=0` after the edge, no `ma_done`, and a late `mem_ack` produces no output.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: access widths,
// FSM states and parameter defaults.
package mem_arb_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam int TIMEOUT_DEFAULT   = 255;
    localparam int IF_STARVE_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_IF,
        ST_BUSY_MA,
        ST_RECOVER
    } arb_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data onto the byte lanes selected by the
// low address bits and produces the matching byte enables.
module store_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  off,
    input  logic [31:0] ma_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        be    = 4'b0000;
        wdata = ma_wdata;
        case (width)
            MW_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{ma_wdata[7:0]}};
            end
            MW_HALF: begin
                // Halfword lane comes from off[1] only; off[0] is dropped.
                be    = 4'b0011 << {off[1], 1'b0};
                wdata = {2{ma_wdata[15:0]}};
            end
            MW_WORD: begin
                be    = 4'b1111;
            end
            default: begin
                be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with MA priority, IF anti-starvation and a per-transaction timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction; arbitrate pending requests
// ST_BUSY_IF | fetch owns the port, waiting for ack or timeout
// ST_BUSY_MA | load/store owns the port, waiting for ack or timeout
// ST_RECOVER | one dead cycle so the finished requester can drop its request
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int IF_STARVE = IF_STARVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic [1:0]  mem_read_ma,
    input  logic [1:0]  mem_write_ma,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    output logic [31:0] ma_rdata,
    output logic        ma_done,
    output logic        ma_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int SW = (IF_STARVE < 1) ? 1 : $clog2(IF_STARVE + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE);

    arb_state_t    state;
    logic [TW-1:0] timer;
    logic [SW-1:0] starve_cnt;

    logic          ma_req;
    logic          ma_is_store;
    logic          if_wins;
    logic          ma_wins;
    logic          busy;
    logic          acked;
    logic          expired;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic          if_addr_lsb_unused;

    assign if_addr_lsb_unused = ^if_addr[1:0];

    store_lane_align u_align (
        .width    (mem_write_ma),
        .off      (ma_addr[1:0]),
        .ma_wdata (ma_wdata),
        .be       (st_be),
        .wdata    (st_wdata)
    );

    assign ma_req      = (|mem_read_ma) | (|mem_write_ma);
    assign ma_is_store = |mem_write_ma;
    assign if_wins     = if_req & (~ma_req | (starve_cnt == STARVE_MAX));
    assign ma_wins     = ma_req & ~if_wins;

    // Reset gates completion so an abandoned transaction never reports done.
    assign busy    = ~reset & ((state == ST_BUSY_IF) | (state == ST_BUSY_MA));
    assign acked   = busy & mem_ack;
    assign expired = busy & ~mem_ack & (timer == '0);

    assign if_done  = (acked | expired) & (state == ST_BUSY_IF);
    assign ma_done  = (acked | expired) & (state == ST_BUSY_MA);
    assign err      = expired;
    assign if_rdata = (acked && state == ST_BUSY_IF) ? mem_rdata : '0;
    assign ma_rdata = (acked && state == ST_BUSY_MA) ? mem_rdata : '0;
    assign if_stall = if_req & ~if_done;
    assign ma_stall = ma_req & ~ma_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (if_wins) begin
                        state      <= ST_BUSY_IF;
                        timer      <= TIMER_LOAD;
                        starve_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {if_addr[31:2], 2'b00};
                        mem_be     <= 4'b1111;
                        mem_wdata  <= '0;
                    end else if (ma_wins) begin
                        state      <= ST_BUSY_MA;
                        timer      <= TIMER_LOAD;
                        if (if_req && starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        mem_req    <= 1'b1;
                        mem_we     <= ma_is_store;
                        mem_addr   <= {ma_addr[31:2], 2'b00};
                        mem_be     <= ma_is_store ? st_be : 4'b1111;
                        mem_wdata  <= ma_is_store ? st_wdata : '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_MA: begin
                    if (mem_ack || timer == '0) begin
                        state   <= ST_RECOVER;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        timer   <= timer - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
